serial_frame_tx: RTL
====================

Name: serial_frame_tx

Overview:
- Transmit end of the team's single-wire serial bit stream; the counterpart of the flip-flop capture/receive chain.
- Accepts a parallel word over a valid/ready handshake and drives it onto one output line as a framed stream: start bit, DATA_W data bits LSB first, stop bit.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a parallel producer and the serial line feeding the receiving DFF stage.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clk cycles each bit is held on tx_serial (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_W  word to send; sampled only at handshake
tx_valid  input  1  producer has a word
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_serial  output  1  serial line; idle level 1
tx_busy  output  1  frame in progress (START/DATA/STOP)
tx_done  output  1  one-cycle pulse: frame completed

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, shift register=0, bit and clock counters=0.
- All outputs are registered. tx_ready is a direct decode of state==IDLE.
- Handshake: transfer occurs on a rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register at that edge.
  - Later changes on tx_data are ignored until the next transfer.
  - tx_valid while not ready is held off; no data is lost and nothing is queued.
- States and transitions:
  - IDLE: tx_serial=1. On transfer -> START.
  - START: tx_serial=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx_serial=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After DATA_W bits -> STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles -> IDLE.
    - tx_done=1 for exactly the one cycle in which state first reads IDLE again.
    - tx_ready rises in that same cycle.
- Latency: tx_serial falls on the first cycle after the transfer edge. A frame occupies exactly (DATA_W+2)*CLKS_PER_BIT cycles.
- Back-to-back: with tx_valid held high, the next transfer happens in the tx_done cycle. Frames are therefore separated by exactly one idle-high cycle.
- Width rules:
  - Clock counter: $clog2(CLKS_PER_BIT) bits, minimum 1. Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit counter: $clog2(DATA_W+1) bits. No overflow is permitted.
- CLKS_PER_BIT=1: each bit lasts exactly one cycle. No extra cycles may be inserted.
- Reset mid-frame: at the reset edge the frame is abandoned.
  - tx_serial=1 on the next cycle.
  - No tx_done pulse is issued.
  - tx_ready=1 on the next cycle.
- rst asserted together with tx_valid: reset wins and no transfer occurs.

Decomposition:
- Shared package serial_frame_pkg holds:
  - state enum IDLE/START/DATA/STOP
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- One natural sub-module: bit_timer (clock-cycle counter, parameter CLKS_PER_BIT, inputs clk/rst/clear, output tick on the last cycle of a bit). It is reused by the matching receiver.
- FSM and shift register stay in serial_frame_tx.

Test Plan:
- Reset: hold rst for 3 cycles with tx_valid=1 -> tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0 throughout; no frame starts.
- Single frame, defaults: send 0xA5.
  - tx_serial holds for 4 cycles each: 0, then 1,0,1,0,0,1,0,1, then 1.
  - Total 40 cycles, then tx_done pulses once with tx_ready=1.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2. tx_data changed mid-frame has no effect on frame 1.
- CLKS_PER_BIT=1, DATA_W=4: send 4'b0110 -> tx_serial sequence 0,0,1,1,0,1 over 6 cycles, tx_done on cycle 7.
- Reset mid-frame: assert rst during data bit 3 of 0x3C -> tx_serial=1 and tx_ready=1 the next cycle; no tx_done; a following send of 0x81 is correct.
- Hold-off: pulse tx_valid while busy, then deassert -> no second frame, tx_serial stays 1 after the first tx_done.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the single-wire serial frame path.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_bit_timer.sv
// Per-bit clock-cycle counter; tick marks the last cycle of each bit period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Held at zero while cleared, so the first bit after a transfer gets its full period.
  assign tick = !clear && (cnt_q == CntLast);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, framed serial-out transmitter: start bit, LSB-first data, stop bit.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [BitW-1:0]   bit_cnt_q;
  logic              serial_q;
  logic              busy_q;
  logic              done_q;
  logic              timer_clear;
  logic              tick;

  assign shift_nxt   = shift_q >> 1;
  assign timer_clear = (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= tx_data;
            bit_cnt_q <= '0;
            serial_q  <= START_BIT;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (tick) begin
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_nxt;
            if (bit_cnt_q == BitLast) begin
              bit_cnt_q <= '0;
              serial_q  <= STOP_BIT;
              state_q   <= STOP;
            end else begin
              // Present the next bit on the same edge the register shifts.
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              serial_q  <= shift_nxt[0];
            end
          end
        end
        STOP: begin
          if (tick) begin
            serial_q <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule
